// File: rtl/jtag_b_master_seq.sv
// JTAG master sequencer: turns DR/IR scan, TAP-reset and idle-run commands into
// TCK/TMS/TDI waveforms, tracks the TAP state and returns the captured TDO bits.
module jtag_b_master_seq #(
    parameter int TCK_DIV = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [5:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    input  logic        tdo
);
    localparam logic [1:0] CMD_DR   = 2'd0;
    localparam logic [1:0] CMD_IR   = 2'd1;
    localparam logic [1:0] CMD_TLR  = 2'd2;
    localparam logic [1:0] CMD_IDLE = 2'd3;
    localparam logic [7:0] DIV_LAST = 8'(TCK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} seq_state_t;
    typedef enum logic [2:0] {
        TAP_TLR, TAP_RTI, TAP_SEL_DR, TAP_SEL_IR, TAP_CAP, TAP_SHIFT, TAP_EXIT1, TAP_UPD
    } tap_state_t;

    seq_state_t  state;
    tap_state_t  tap;
    logic [7:0]  div_cnt;
    logic [6:0]  step;
    logic [6:0]  last_step;
    logic [1:0]  typ;
    logic [5:0]  len;
    logic        pre;
    logic [31:0] data_sh;
    logic [4:0]  bit_cnt;

    logic [5:0]  len_in;
    logic        pre_in;
    logic [6:0]  last_in;
    logic        tms_first;
    logic        accept;

    // DR and IR paths share CAP/SHIFT/EXIT1/UPD; Pause is never requested here.
    function automatic tap_state_t tap_next(input tap_state_t s, input logic m);
        tap_state_t n;
        case (s)
            TAP_TLR:    n = m ? TAP_TLR    : TAP_RTI;
            TAP_RTI:    n = m ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR: n = m ? TAP_SEL_IR : TAP_CAP;
            TAP_SEL_IR: n = m ? TAP_TLR    : TAP_CAP;
            TAP_CAP:    n = m ? TAP_EXIT1  : TAP_SHIFT;
            TAP_SHIFT:  n = m ? TAP_EXIT1  : TAP_SHIFT;
            TAP_EXIT1:  n = m ? TAP_UPD    : TAP_EXIT1;
            default:    n = m ? TAP_SEL_DR : TAP_RTI;
        endcase
        return n;
    endfunction

    // TMS for TCK number k of a command; p is the leading TLR->RTI step.
    function automatic logic step_tms(input logic [1:0] t, input logic [5:0] n,
                                      input logic p, input logic [6:0] k);
        logic [6:0] kp;
        logic [6:0] last_sh;
        logic       r;
        kp      = k - {6'd0, p};
        last_sh = ((t == CMD_IR) ? 7'd3 : 7'd2) + {1'b0, n};
        r       = 1'b0;
        case (t)
            CMD_TLR:  r = (k < 7'd5);
            CMD_IDLE: r = 1'b0;
            default: begin
                if (!(p && k == 7'd0))
                    r = (kp == 7'd0) || (t == CMD_IR && kp == 7'd1) ||
                        (kp == last_sh) || (kp == last_sh + 7'd1);
            end
        endcase
        return r;
    endfunction

    always_comb begin
        len_in = cmd_len;
        if (cmd_len == 6'd0)
            len_in = 6'd1;
        else if (cmd_len > 6'd32 && cmd_type != CMD_IDLE)
            len_in = 6'd32;
        pre_in = (tap == TAP_TLR) && (cmd_type != CMD_TLR);
        case (cmd_type)
            CMD_DR:  last_in = {1'b0, len_in} + 7'd4 + {6'd0, pre_in};
            CMD_IR:  last_in = {1'b0, len_in} + 7'd5 + {6'd0, pre_in};
            CMD_TLR: last_in = 7'd5;
            default: last_in = {1'b0, len_in} - 7'd1 + {6'd0, pre_in};
        endcase
        tms_first = !pre_in && (cmd_type != CMD_IDLE);
    end

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            tap       <= TAP_TLR;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            div_cnt   <= 8'd0;
            step      <= 7'd0;
            last_step <= 7'd0;
            typ       <= CMD_DR;
            len       <= 6'd0;
            pre       <= 1'b0;
            data_sh   <= 32'd0;
            bit_cnt   <= 5'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        state     <= S_RUN;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        typ       <= cmd_type;
                        len       <= len_in;
                        pre       <= pre_in;
                        last_step <= last_in;
                        data_sh   <= cmd_data;
                        rsp_data  <= 32'd0;
                        bit_cnt   <= 5'd0;
                        step      <= 7'd0;
                        div_cnt   <= 8'd0;
                        tck       <= 1'b0;
                        tms       <= tms_first;
                        tdi       <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= 8'd0;
                        if (!tck) begin
                            tck <= 1'b1;
                            tap <= tap_next(tap, tms);
                            if (tap == TAP_SHIFT) begin
                                rsp_data[bit_cnt] <= tdo;
                                bit_cnt           <= bit_cnt + 5'd1;
                                data_sh           <= data_sh >> 1;
                            end
                        end else begin
                            tck <= 1'b0;
                            // Falling edge: either the command is done or set up the next TCK.
                            if (step == last_step) begin
                                state     <= S_RESP;
                                rsp_valid <= 1'b1;
                                tdi       <= 1'b0;
                            end else begin
                                step <= step + 7'd1;
                                tms  <= step_tms(typ, len, pre, step + 7'd1);
                                tdi  <= (tap == TAP_SHIFT) ? data_sh[0] : 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/jtag_b_master_seq.md
JTAG_B_MASTER_SEQ -- requirements
Module: jtag_b_master_seq

Interface
REQ-001 Parameter TCK_DIV, default 2, is the number of clock cycles per TCK half-period (legal values 1 to 255).
REQ-002 Port clock, input, 1 bit, is the single system clock; every flop is on its rising edge.
REQ-003 Port reset, input, 1 bit, is the reset: synchronous and active-high.
REQ-004 Port cmd_valid, input, 1 bit, means a command is offered.
REQ-005 Port cmd_ready, output, 1 bit, means a command is accepted this cycle when cmd_valid is also high.
REQ-006 Port cmd_type, input, 2 bits, selects the command: 0 DR scan, 1 IR scan, 2 TAP reset (TLR), 3 idle run.
REQ-007 Port cmd_len, input, 6 bits, gives the scan bit count for DR/IR, or the TCK count for idle.
REQ-008 Port cmd_data, input, 32 bits, is the TDI data, shifted LSB first.
REQ-009 Port rsp_valid, output, 1 bit, means a response is pending.
REQ-010 Port rsp_ready, input, 1 bit, means the consumer takes the response.
REQ-011 Port rsp_data, output, 32 bits, is the captured TDO data.
REQ-012 Port busy, output, 1 bit, is high from command accept until the response is taken.
REQ-013 Port tck, output, 1 bit, is the JTAG test clock.
REQ-014 Port tms, output, 1 bit, is JTAG test mode select.
REQ-015 Port tdi, output, 1 bit, is JTAG test data in (toward the TAP).
REQ-016 Port tdo, input, 1 bit, is JTAG test data out (from the TAP).

Function
REQ-017 The block SHALL track the TAP state in a register with states TLR, RTI, SEL_DR, SEL_IR, CAP, SHIFT, EXIT1, UPD, advanced per IEEE 1149.1 on each TCK rise using the driven tms.
REQ-018 The sequencer FSM SHALL have states IDLE, RUN, RESP.
- IDLE->RUN on accept.
- RUN->RESP when the final TCK of the command completes.
- RESP->IDLE on a cycle with rsp_valid and rsp_ready both high.
REQ-019 cmd_ready SHALL equal (FSM==IDLE); cmd_valid is ignored in other states.
REQ-020 TCK timing:
- tck SHALL be 0 in IDLE and RESP.
- In RUN, tck toggles every TCK_DIV clocks, starting low, so one TCK period is 2*TCK_DIV clocks.
REQ-021 tms/tdi SHALL update only on the clock where tck goes 0 (and on the first RUN cycle); tdo SHALL be sampled on the clock where tck goes 1 while the tracked state is SHIFT.
REQ-022 A DR scan from RTI SHALL drive the tms sequence 1,0,0, then len bits with tms=0 except the last bit tms=1, then 1,0: 13 TCKs for len=8, ending in RTI.
REQ-023 An IR scan SHALL insert one extra tms=1 after SEL_DR (via SEL_IR), giving len+6 TCKs.
REQ-024 If the tracked state is TLR when a DR/IR/idle command starts, one leading tms=0 TCK SHALL be prepended to reach RTI.
REQ-025 A TLR command SHALL drive 5 TCKs with tms=1, then 1 TCK with tms=0, ending in RTI.
REQ-026 An idle command SHALL drive cmd_len TCKs with tms=0 (0 is treated as 1).
REQ-027 Length rules:
- cmd_len of 0 for DR/IR SHALL be treated as 1; values above 32 SHALL be clamped to 32.
- Shift bit i SHALL drive tdi=cmd_data[i] and capture tdo into rsp_data[i].
- rsp_data bits at or above len SHALL be 0.
REQ-028 tdi SHALL be 0 outside SHIFT.
REQ-029 Commands and data SHALL be registered at accept; later input changes have no effect.
REQ-030 rsp_valid SHALL be high exactly in RESP, with rsp_data stable while it is high. TLR and idle commands respond with rsp_data=0.

Reset
REQ-031 On a clock with reset high, the block SHALL set: FSM IDLE, tracked TAP state TLR, tck=0, tms=1, tdi=0, rsp_valid=0, rsp_data=0, busy=0, cmd_ready=0 during reset and 1 the following cycle.
REQ-032 Reset mid-command SHALL abort without a response; the next DR/IR command SHALL prepend the tms=0 TCK.

Verification
REQ-033 Reset, then DR scan (len=8, data=0xA5), TCK_DIV=2, with a TAP model -> 14 TCKs (prepend + 13), 56 RUN clocks, tdi bits 1,0,1,0,0,1,0,1, and rsp_data equal to the model's 8 captured bits.
REQ-034 IR scan len=4 data=0x3 from RTI -> tms sequence 1,1,0,0,0,0,0,1,1,0 (10 TCKs); tracked state ends RTI.
REQ-035 TLR command -> tms 1,1,1,1,1,0; rsp_valid with rsp_data=0.
REQ-036 DR len=40 -> clamped to 32 shift bits; len=0 -> 1 shift bit, rsp_data[31:1]=0.
REQ-037 rsp_ready held low for 10 cycles -> rsp_valid and rsp_data held, cmd_ready=0, and a new cmd_valid is ignored.
REQ-038 Reset asserted during the shift phase -> tck=0 and tms=1 on the next clock, no rsp_valid; the next DR scan starts with tms=0.
